// File: rtl/led_pattern_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pattern_monitor: receive-side checker for a 10-bit rotating one-hot LED
// bus; optional stall watchdog under macro STALL_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module led_pattern_monitor #(
  parameter int LOCK_STEPS   = 3,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_err,
  input  logic [9:0]  leds,
  output logic [3:0]  pos,
  output logic        dir_left,
  output logic        locked,
  output logic [15:0] step_cnt,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] c_POS_NONE = 4'hF;
  localparam logic [3:0] c_LOCK     = 4'(LOCK_STEPS);

  function automatic logic f_onehot(input logic [9:0] x);
    return (x != 10'd0) && ((x & (x - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] f_index(input logic [9:0] x);
    logic [3:0] idx;
    idx = c_POS_NONE;
    for (int i = 0; i < 10; i++) begin
      if (x[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_leds_q, w_leds_q_nxt;
  logic [3:0]  r_pos, w_pos_nxt;
  logic        r_dir_left, w_dir_left_nxt;
  logic [3:0]  r_streak, w_streak_nxt;
  logic [15:0] r_step_cnt, w_step_cnt_nxt;
  logic        r_fault, w_fault_nxt;
  logic [1:0]  r_fault_code, w_fault_code_nxt;

  logic        w_onehot, w_left, w_right, w_step, w_change;
  logic [3:0]  w_idx, w_streak_new;

  assign w_onehot = f_onehot(leds);
  assign w_idx    = f_index(leds);
  assign w_left   = (leds == {r_leds_q[8:0], r_leds_q[9]});
  assign w_right  = (leds == {r_leds_q[0], r_leds_q[9:1]});
  assign w_step   = w_onehot && (w_left || w_right);
  assign w_change = en && (leds != r_leds_q);
  // A step continues the streak unless it reverses an established direction.
  assign w_streak_new = ((r_streak == 4'd0) || (w_left == r_dir_left)) ? r_streak + 4'd1 : 4'd1;

`ifdef STALL_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic                    r_stall, w_stall_nxt;
  assign w_tmo_inc = r_tmo + 1'b1;
`else
  logic [TIMEOUT_BITS-1:0] w_unused_tmo;
  assign w_unused_tmo = '0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_leds_q_nxt     = r_leds_q;
    w_pos_nxt        = r_pos;
    w_dir_left_nxt   = r_dir_left;
    w_streak_nxt     = r_streak;
    w_step_cnt_nxt   = r_step_cnt;
    w_fault_nxt      = r_fault;
    w_fault_code_nxt = r_fault_code;
`ifdef STALL_TIMEOUT_EN
    w_tmo_nxt        = r_tmo;
    w_stall_nxt      = r_stall;
`endif
    if (en) w_leds_q_nxt = leds;

    if (clr_err) begin
      w_state_nxt      = S_IDLE;
      w_pos_nxt        = c_POS_NONE;
      w_streak_nxt     = 4'd0;
      w_fault_nxt      = 1'b0;
      w_fault_code_nxt = 2'b00;
`ifdef STALL_TIMEOUT_EN
      w_stall_nxt      = 1'b0;
`endif
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          if (w_onehot) begin
            w_state_nxt  = S_ACQUIRE;
            w_pos_nxt    = w_idx;
            w_streak_nxt = 4'd0;
          end
        end
        S_ACQUIRE, S_LOCKED: begin
          if (w_change) begin
            if (!w_step) begin
              w_state_nxt = S_FAULT;
              w_fault_nxt = 1'b1;
              w_pos_nxt   = c_POS_NONE;
              if (r_fault_code == 2'b00) w_fault_code_nxt = w_onehot ? 2'b10 : 2'b01;
            end else begin
              w_pos_nxt      = w_idx;
              w_step_cnt_nxt = r_step_cnt + 16'd1;
              w_dir_left_nxt = w_left;
              if (r_state == S_ACQUIRE) begin
                w_streak_nxt = w_streak_new;
                if (w_streak_new == c_LOCK) w_state_nxt = S_LOCKED;
              end else if (w_left != r_dir_left) begin
                w_state_nxt  = S_ACQUIRE;
                w_streak_nxt = 4'd1;
              end
            end
          end
`ifdef STALL_TIMEOUT_EN
          else if (r_state == S_LOCKED) begin
            w_tmo_nxt = w_tmo_inc;
            if (w_tmo_inc == {TIMEOUT_BITS{1'b1}}) begin
              w_stall_nxt  = 1'b1;
              w_state_nxt  = S_ACQUIRE;
              w_streak_nxt = 4'd0;
            end
          end
          if (w_change) w_tmo_nxt = '0;
`endif
        end
        S_FAULT: begin
          w_pos_nxt = c_POS_NONE;
        end
      endcase
    end
`ifdef STALL_TIMEOUT_EN
    if (w_state_nxt != S_LOCKED) w_tmo_nxt = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_leds_q     <= 10'd0;
      r_pos        <= c_POS_NONE;
      r_dir_left   <= 1'b0;
      r_streak     <= 4'd0;
      r_step_cnt   <= 16'd0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_leds_q     <= w_leds_q_nxt;
      r_pos        <= w_pos_nxt;
      r_dir_left   <= w_dir_left_nxt;
      r_streak     <= w_streak_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

`ifdef STALL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo   <= '0;
      r_stall <= 1'b0;
    end else begin
      r_tmo   <= w_tmo_nxt;
      r_stall <= w_stall_nxt;
    end
  end
  assign stall = r_stall;
`else
  assign stall = 1'b0;
`endif

  assign pos        = r_pos;
  assign dir_left   = r_dir_left;
  assign locked     = (r_state == S_LOCKED);
  assign step_cnt   = r_step_cnt;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: doc/led_pattern_monitor.md
Name: led_pattern_monitor

Overview:
- Receive-side checker for the 10-bit rotating one-hot LED pattern bus driven by the board's pattern generators.
- Samples the bus each enabled cycle and decodes the lit position.
- Infers the rotation direction and locks onto a consistent rotation.
- Counts steps and latches protocol faults (non-one-hot value, illegal jump); used for self-test and on-board status display.

Parameters:
- LOCK_STEPS, 3, consecutive same-direction valid steps required to enter LOCKED (legal 1..15).
- TIMEOUT_BITS, 24, width of stall counter; only used with STALL_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  sample enable; when low, all state except clr_err handling holds
- clr_err  input  1  clears latched fault, returns FSM to IDLE
- leds  input  10  observed pattern bus
- pos  output  4  index 0..9 of lit bit in last accepted sample; 4'hF = none/invalid
- dir_left  output  1  1 = rotating left (bit i -> i+1, 9 -> 0), 0 = right
- locked  output  1  high while FSM in LOCKED
- step_cnt  output  16  count of valid steps accepted in ACQUIRE or LOCKED
- fault  output  1  sticky fault flag
- fault_code  output  2  00 none, 01 not one-hot, 10 non-adjacent jump; first fault only
- stall  output  1  sticky stall flag (tied 0 without STALL_TIMEOUT_EN)

Behaviour:
- Reset values: pos=4'hF, dir_left=0, locked=0, step_cnt=0, fault=0, fault_code=00, stall=0, internal leds_q=0, streak=0, FSM=IDLE.
- All outputs registered; the response to a sample on leds appears one clock after the edge at which it is sampled.
- leds_q <= leds on every en cycle.
- Change event: en && leds != leds_q.
- Onehot(x): exactly one bit set.
- Step left: leds == {leds_q[8:0], leds_q[9]}.
- Step right: leds == {leds_q[0], leds_q[9:1]}.
- Wrap 9->0 is a legal left step; 0->9 is a legal right step.
- FSM states IDLE, ACQUIRE, LOCKED, FAULT:
  - IDLE: on en with onehot(leds) -> ACQUIRE, pos=index, streak=0. Non-one-hot values are ignored here (power-up garbage); no fault.
  - ACQUIRE, change event:
    - not onehot -> FAULT, code 01.
    - onehot but not an adjacent step -> FAULT, code 10.
    - valid step: pos updates, step_cnt+1.
      - If streak==0 or the direction matches dir_left: dir_left set, streak+1.
      - Otherwise: dir_left flips, streak=1.
      - If the new streak == LOCK_STEPS -> LOCKED.
  - LOCKED, change event:
    - same-direction step: pos, step_cnt+1.
    - opposite step -> ACQUIRE, dir_left flips, streak=1, step_cnt+1.
    - not onehot -> FAULT, code 01.
    - non-adjacent -> FAULT, code 10.
  - FAULT: fault=1, pos=4'hF, locked=0; samples ignored. Stays until clr_err or rst.
- No change event (bus static): state holds; streak is not reset.
- step_cnt wraps 16'hFFFF -> 0 silently.
- fault_code holds the first fault until cleared.
- clr_err (independent of en):
  - FSM -> IDLE; fault, fault_code, stall cleared; pos=4'hF.
  - step_cnt is not cleared.
  - clr_err has priority over any same-cycle fault detection.
- rst has priority over everything; mid-rotation reset returns to reset values at the next edge.
- en low: leds_q, FSM, counters frozen; outputs hold.

Optional Feature:
- Macro STALL_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_BITS-wide counter increments on each en cycle in LOCKED without a change event, and zeroes on any change event or on leaving LOCKED.
  - When it reaches all-ones: stall=1 (sticky until clr_err/rst), FSM -> ACQUIRE, streak=0, counter zeroed.
- When undefined: no counter logic; stall tied to 0.

Test Plan:
- Reset, en=1, drive 0x001, 0x002, 0x004, 0x008, each held 4 cycles (LOCK_STEPS=3):
  - locked=1 one clock after 0x008 is sampled; dir_left=1, pos=3, step_cnt=3, fault=0.
- Locked left, drive 0x200 then 0x001:
  - 9->0 wrap accepted: pos=0, locked stays 1, step_cnt increments.
- Locked left at pos=4 (0x010), drive 0x008:
  - locked=0 (ACQUIRE), dir_left=0, streak=1.
  - Then 0x004 and 0x002 -> locked=1 again with dir_left=0.
- Locked, drive 0x018:
  - fault=1, fault_code=01, pos=F, locked=0.
  - Then drive 0x004 -> fault_code remains 01.
  - Pulse clr_err -> fault=0, IDLE; next one-hot sample -> ACQUIRE.
- ACQUIRE at 0x004, drive 0x020 -> fault_code=10.
  - clr_err asserted in the same cycle as a 0x030 sample -> no fault, IDLE.
- With STALL_TIMEOUT_EN and TIMEOUT_BITS=4, locked, hold the bus static for 15 en cycles:
  - stall=1, locked=0.
  - en low for 20 cycles leaves stall/timeout unchanged.
